// File: rtl/ifetch_if.sv
// Fetch-unit bus bundle: instruction memory port, redirect request and the
// decoded head-of-buffer output stream. The master modport is the fetch unit,
// and the slave modport is its surroundings (imem, branch unit, decoder).
interface ifetch_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_q;
  logic              redirect_en;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] pc_out;
  logic [4:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        shamt;
  logic [4:0]        aluop;
  logic [31:0]       imm_sext;

  modport master (
    output imem_addr,
    input  imem_q,
    input  redirect_en,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output instr,
    output pc_out,
    output opcode,
    output rd,
    output rs,
    output rt,
    output shamt,
    output aluop,
    output imm_sext
  );

  modport slave (
    input  imem_addr,
    output imem_q,
    output redirect_en,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  instr,
    input  pc_out,
    input  opcode,
    input  rd,
    input  rs,
    input  rt,
    input  shamt,
    input  aluop,
    input  imm_sext
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch unit: it drives a synchronous imem from the PC, then captures
// each returning word into a small in-order buffer and presents the head word
// with its decoded fields.
// Build option IFETCH_SKID_BUF_EN: when defined, the buffer holds two entries
// and the unit fetches one word per cycle. When undefined, the buffer holds one
// entry and the unit fetches at most one word every two cycles.
module ifetch #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic      clock,
  input logic      reset,
  ifetch_if.master bus
);

`ifdef IFETCH_SKID_BUF_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [1:0] DEPTH_L = 2'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] inflight_pc_reg;
  logic              inflight_reg;
  logic [1:0]        occ_reg;

  logic              head_valid;
  logic              pop;
  logic              issue;
  logic              push;
  logic [1:0]        occ_after;
  logic [1:0]        wr_idx;
  logic [31:0]       head_instr;

  assign head_valid = (occ_reg != 2'd0);
  assign pop        = head_valid & bus.out_ready;
  // This is the occupancy once the word in flight has landed and the pop has
  // happened. A new issue is allowed only if that word will also find a free slot.
  assign occ_after  = occ_reg + {1'b0, inflight_reg} - {1'b0, pop};
  // The arriving word goes directly behind whatever is left after this cycle's pop.
  assign wr_idx     = occ_reg - {1'b0, pop};

  // State register: IDLE marks an empty pipe after reset or redirect
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next state: leave IDLE on the first issue; a redirect always returns to IDLE
  always_comb begin
    state_next = state_reg;
    if (bus.redirect_en)                  state_next = IDLE;
    else if (state_reg == IDLE && issue)  state_next = RUN;
  end

  // Outputs of the FSM: issue/push enables; nothing can be in flight in IDLE
  always_comb begin
    issue = 1'b0;
    push  = 1'b0;
    case (state_reg)
      IDLE: issue = !bus.redirect_en && (occ_after < DEPTH_L);
      RUN: begin
        issue = !bus.redirect_en && (occ_after < DEPTH_L);
        push  = inflight_reg && !bus.redirect_en;
      end
      default: ;
    endcase
  end

  // PC, in-flight tracking and occupancy; a redirect flushes everything
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_reg          <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      occ_reg         <= 2'd0;
    end else if (bus.redirect_en) begin
      pc_reg       <= bus.redirect_pc;
      inflight_reg <= 1'b0;
      occ_reg      <= 2'd0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        inflight_pc_reg <= pc_reg;
        pc_reg          <= pc_reg + ADDR_W'(1);
      end
      occ_reg <= occ_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  // Buffer slots: slot 0 is the head. A pop shifts entries toward the head,
  // and a push writes at wr_idx. The push wins over the shift in that slot.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [31:0]       slot_instr_reg;
      logic [ADDR_W-1:0] slot_pc_reg;
      logic [31:0]       shift_instr;
      logic [ADDR_W-1:0] shift_pc;

      if (gi < DEPTH - 1) begin : g_next
        assign shift_instr = g_slot[gi+1].slot_instr_reg;
        assign shift_pc    = g_slot[gi+1].slot_pc_reg;
      end else begin : g_last
        assign shift_instr = slot_instr_reg;
        assign shift_pc    = slot_pc_reg;
      end

      // Per-slot storage update
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          slot_instr_reg <= '0;
          slot_pc_reg    <= '0;
        end else if (!bus.redirect_en) begin
          if (push && wr_idx == 2'(gi)) begin
            slot_instr_reg <= bus.imem_q;
            slot_pc_reg    <= inflight_pc_reg;
          end else if (pop) begin
            slot_instr_reg <= shift_instr;
            slot_pc_reg    <= shift_pc;
          end
        end
      end
    end
  endgenerate

  // The head fields read as zero whenever the buffer is empty.
  assign head_instr    = head_valid ? g_slot[0].slot_instr_reg : 32'd0;
  assign bus.imem_addr = pc_reg;
  assign bus.out_valid = head_valid;
  assign bus.instr     = head_instr;
  assign bus.pc_out    = head_valid ? g_slot[0].slot_pc_reg : '0;
  assign bus.opcode    = head_instr[31:27];
  assign bus.rd        = head_instr[26:22];
  assign bus.rs        = head_instr[21:17];
  assign bus.rt        = head_instr[16:12];
  assign bus.shamt     = head_instr[11:7];
  assign bus.aluop     = head_instr[6:2];
  assign bus.imm_sext  = {{15{head_instr[16]}}, head_instr[16:0]};

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch. The imem model returns an address-based word, and
// a few addresses return fixed decode vectors. The bench covers both buffer depths
// and selects the depth through IFETCH_SKID_BUF_EN, the same way the design does.
module tb_ifetch;
  localparam int          ADDR_W   = 12;
  localparam logic [11:0] RESET_PC = 12'h000;
`ifdef IFETCH_SKID_BUF_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  ifetch_if #(.ADDR_W(ADDR_W)) bus ();

  ifetch #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    if (a == 12'h040) return 32'h3A8C_0005;
    if (a == 12'h041) return 32'h0001_8003;
    return {20'hC3A50, a};
  endfunction

  // synchronous imem: data for the address presented at an edge is valid after it
  always @(posedge clock) bus.imem_q <= mem_word(bus.imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic expect_pops(input logic [11:0] first, input int n, input int budget);
    logic [11:0] want;
    int          got;
    want = first;
    got  = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      if (bus.out_valid && bus.out_ready) begin
        $display("pop pc=0x%03h instr=0x%08h", bus.pc_out, bus.instr);
        check("pop_pc", 32'(bus.pc_out), 32'(want));
        check("pop_instr", bus.instr, mem_word(want));
        want = want + 12'd1;
        got++;
      end
      if (got < n) step();
    end
    check("pop_count", got, n);
  endtask

  task automatic wait_head(input logic [11:0] pc, input int budget);
    int found;
    found = 0;
    for (int c = 0; c < budget; c++) begin
      if (bus.out_valid && bus.pc_out == pc) begin
        found = 1;
        break;
      end
      step();
    end
    check($sformatf("wait_head_%03h", pc), found, 1);
  endtask

  task automatic redirect(input logic [11:0] target);
    bus.redirect_en = 1'b1;
    bus.redirect_pc = target;
    step();
    bus.redirect_en = 1'b0;
    $display("redirect to 0x%03h", target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.redirect_en = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready   = 1'b0;
    reset           = 1'b1;
    #3;
    check("rst_valid", bus.out_valid, 0);
    check("rst_instr", bus.instr, 0);
    check("rst_pc_out", 32'(bus.pc_out), 0);
    check("rst_addr", 32'(bus.imem_addr), 32'(RESET_PC));

    // stream from reset with the consumer always ready
    @(negedge clock);
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("e1_valid", bus.out_valid, 0);
    check("e1_addr", 32'(bus.imem_addr), 32'(RESET_PC + 12'd1));
    for (int j = 0; j < 8; j++) begin
      logic       ev;
      logic [11:0] ep;
      step();
      ev = SKID ? 1'b1 : ((j % 2) == 0);
      ep = !ev ? 12'd0 : (SKID ? 12'(j) : 12'(j / 2));
      $display("cycle %0d valid=%0d pc=0x%03h", j + 2, bus.out_valid, bus.pc_out);
      check("rate_valid", bus.out_valid, ev);
      check("rate_pc", 32'(bus.pc_out), 32'(ep));
    end

    // redirect near the top of the address space; check latency and wrap
    redirect(12'hFFE);
    check("rd_valid", bus.out_valid, 0);
    check("rd_addr", 32'(bus.imem_addr), 32'hFFE);
    check("rd_empty_instr", bus.instr, 0);
    check("rd_empty_imm", bus.imm_sext, 0);
    check("rd_empty_opcode", 32'(bus.opcode), 0);
    step();
    check("rd_issue_valid", bus.out_valid, 0);
    step();
    check("rd_lat_valid", bus.out_valid, 1);
    check("rd_lat_pc", 32'(bus.pc_out), 32'hFFE);
    expect_pops(12'hFFE, 3, 16);

    // backpressure: hold the head at 0x105 for ten cycles
    redirect(12'h100);
    wait_head(12'h105, 40);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("stall_valid", bus.out_valid, 1);
      check("stall_pc", 32'(bus.pc_out), 32'h105);
      check("stall_addr", 32'(bus.imem_addr), SKID ? 32'h107 : 32'h106);
    end
    bus.out_ready = 1'b1;
    expect_pops(12'h105, 3, 16);

    // redirect while the buffer is full: stale words must be discarded
    bus.out_ready = 1'b0;
    repeat (4) step();
    redirect(12'h100);
    check("flush_valid", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    expect_pops(12'h100, 2, 12);

    // field decode on fixed vectors
    bus.out_ready = 1'b0;
    redirect(12'h040);
    wait_head(12'h040, 10);
    check("f_opcode", 32'(bus.opcode), 7);
    check("f_rd", 32'(bus.rd), 10);
    check("f_rs", 32'(bus.rs), 6);
    check("f_rt", 32'(bus.rt), 0);
    check("f_shamt", 32'(bus.shamt), 0);
    check("f_aluop", 32'(bus.aluop), 1);
    check("f_imm", bus.imm_sext, 32'h0000_0005);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    wait_head(12'h041, 10);
    check("f_imm_neg", bus.imm_sext, 32'hFFFF_8003);

    // asynchronous reset in the middle of a low clock phase with a full buffer
    repeat (3) step();
    check("pre_rst_valid", bus.out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_pc_out", 32'(bus.pc_out), 0);
    check("arst_instr", bus.instr, 0);
    check("arst_addr", 32'(bus.imem_addr), 32'(RESET_PC));
    @(negedge clock);
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("post_rst_issue", 32'(bus.imem_addr), 32'(RESET_PC + 12'd1));
    check("post_rst_valid", bus.out_valid, 0);
    expect_pops(RESET_PC, 3, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
